// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU op codes, branch conditions
// and the multiply/divide handshake FSM states.
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SRL   = 4'd3,
    ALU_SRA   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_XOR   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSA = 4'd10,
    ALU_PASSB = 4'd11,
    ALU_B4    = 4'd12,
    ALU_IDLE  = 4'd13,
    ALU_MOP   = 4'd14
  } alu_op_e;

  localparam logic [2:0] F3_EQ  = 3'd0;
  localparam logic [2:0] F3_NE  = 3'd1;
  localparam logic [2:0] F3_LT  = 3'd4;
  localparam logic [2:0] F3_GE  = 3'd5;
  localparam logic [2:0] F3_LTU = 3'd6;
  localparam logic [2:0] F3_GEU = 3'd7;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } m_state_e;

endpackage

// File: rtl/exec_unit_branch_cmp.sv
// Branch condition evaluator; unlisted fun3 codes are never taken.
module branch_cmp
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      fun3,
  output logic            cond
);

  always_comb begin
    cond = 1'b0;
    case (fun3)
      F3_EQ:   cond = (a == b);
      F3_NE:   cond = (a != b);
      F3_LT:   cond = ($signed(a) < $signed(b));
      F3_GE:   cond = ($signed(a) >= $signed(b));
      F3_LTU:  cond = (a < b);
      F3_GEU:  cond = (a >= b);
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: ALU, branch resolution with redirect/flush, and a stalling
// handshake to an external multiply/divide unit.
module exec_unit
  import exec_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CACHE_READY,
  input  logic             IN_VALID,
  input  logic [3:0]       ALU_CNT,
  input  logic [2:0]       FUN3,
  input  logic             CBRANCH,
  input  logic             JUMP,
  input  logic [XLEN-1:0]  OP_A,
  input  logic [XLEN-1:0]  OP_B,
  input  logic [XLEN-1:0]  CMP1,
  input  logic [XLEN-1:0]  CMP2,
  input  logic [XLEN-1:0]  PC,
  input  logic [XLEN-1:0]  PC_ID,
  input  logic [XLEN-1:0]  JUMP_BASE,
  input  logic [XLEN-1:0]  JUMP_OFF,
  input  logic [XLEN-1:0]  M_RESULT,
  input  logic             M_READY,
  output logic             M_START,
  output logic             OUT_VALID,
  output logic [XLEN-1:0]  WB_DATA,
  output logic [XLEN-1:0]  DATA_ADDR,
  output logic             JUMP_FINAL,
  output logic [XLEN-1:0]  JUMP_ADDR,
  output logic             FLUSH,
  output logic             STALL,
  output logic [CNT_W-1:0] MISPREDICT_CNT
);

  localparam int SHW = $clog2(XLEN);

  m_state_e         state_q, state_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  wb_q, wb_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             m_got_q, m_got_d;
  logic [XLEN-1:0]  m_res_q, m_res_d;

  logic            cond, flushing, eff_valid, is_m, m_done, launch, complete, redirect;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;

  branch_cmp #(.XLEN(XLEN)) u_cmp (.a(CMP1), .b(CMP2), .fun3(FUN3), .cond(cond));

  always_comb begin
    shamt   = OP_A[SHW-1:0];
    alu_res = '0;
    case (ALU_CNT)
      ALU_ADD:   alu_res = OP_A + OP_B;
      ALU_SUB:   alu_res = OP_B - OP_A;
      ALU_SLL:   alu_res = OP_B << shamt;
      ALU_SRL:   alu_res = OP_B >> shamt;
      ALU_SRA:   alu_res = $signed(OP_B) >>> shamt;
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(OP_B) < $signed(OP_A))};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (OP_B < OP_A)};
      ALU_XOR:   alu_res = OP_A ^ OP_B;
      ALU_OR:    alu_res = OP_A | OP_B;
      ALU_AND:   alu_res = OP_A & OP_B;
      ALU_PASSA: alu_res = OP_A;
      ALU_PASSB: alu_res = OP_B;
      ALU_B4:    alu_res = OP_B + XLEN'(4);
      default:   alu_res = '0;
    endcase
  end

  always_comb begin
    flushing   = (flush_cnt_q != 4'd0);
    eff_valid  = IN_VALID & ~flushing;
    is_m       = (ALU_CNT == ALU_MOP);
    // A result seen while frozen is remembered so the wait can end later.
    m_done     = M_READY | m_got_q;
    JUMP_ADDR  = JUMP_BASE + JUMP_OFF;
    JUMP_FINAL = eff_valid & (JUMP | (CBRANCH & cond));
    launch     = (state_q == M_IDLE) & eff_valid & is_m;
    STALL      = launch | ((state_q == M_WAIT) & ~m_done);
    M_START    = launch & CACHE_READY & ~RST;
    complete   = CACHE_READY & ~STALL & eff_valid;
    redirect   = complete & (JUMP_FINAL ? (PC_ID != JUMP_ADDR) : (PC_ID != PC + XLEN'(4)));

    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    out_valid_d = out_valid_q;
    wb_d        = wb_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    m_got_d     = m_got_q;
    m_res_d     = m_res_q;

    if (!CACHE_READY && (state_q == M_WAIT) && M_READY && !m_got_q) begin
      m_got_d = 1'b1;
      m_res_d = M_RESULT;
    end

    if (CACHE_READY) begin
      out_valid_d = 1'b0;
      if (flushing) flush_cnt_d = flush_cnt_q - 4'd1;
      case (state_q)
        M_IDLE: if (launch) state_d = M_WAIT;
        M_WAIT: if (m_done) begin
          state_d = M_IDLE;
          m_got_d = 1'b0;
        end
        default: state_d = M_IDLE;
      endcase
      if (complete) begin
        out_valid_d = 1'b1;
        addr_d      = OP_A + OP_B;
        if (state_q == M_WAIT) wb_d = m_got_q ? m_res_q : M_RESULT;
        else                   wb_d = alu_res;
      end
      if (redirect) begin
        flush_cnt_d = 4'(FLUSH_CYCLES);
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= M_IDLE;
      flush_cnt_q <= '0;
      out_valid_q <= 1'b0;
      wb_q        <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      m_got_q     <= 1'b0;
      m_res_q     <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      out_valid_q <= out_valid_d;
      wb_q        <= wb_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      m_got_q     <= m_got_d;
      m_res_q     <= m_res_d;
    end
  end

  assign FLUSH          = flushing;
  assign OUT_VALID      = out_valid_q;
  assign WB_DATA        = wb_q;
  assign DATA_ADDR      = addr_q;
  assign MISPREDICT_CNT = cnt_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: expected writebacks go through a scoreboard
// queue checked by an independent monitor; a CNT_W=2 copy shares the inputs.
module tb_exec_unit;
  import exec_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, CACHE_READY, IN_VALID, CBRANCH, JUMP, M_READY;
  logic [3:0]  ALU_CNT;
  logic [2:0]  FUN3;
  logic [31:0] OP_A, OP_B, CMP1, CMP2, PC, PC_ID, JUMP_BASE, JUMP_OFF, M_RESULT;

  logic        M_START, OUT_VALID, JUMP_FINAL, FLUSH, STALL;
  logic [31:0] WB_DATA, DATA_ADDR, JUMP_ADDR;
  logic [15:0] MISPREDICT_CNT;

  logic        d2_m_start, d2_out_valid, d2_jump_final, d2_flush, d2_stall;
  logic [31:0] d2_wb, d2_addr, d2_jaddr;
  logic [1:0]  d2_cnt;

  exec_unit dut (
    .CLK(CLK), .RST(RST), .CACHE_READY(CACHE_READY), .IN_VALID(IN_VALID),
    .ALU_CNT(ALU_CNT), .FUN3(FUN3), .CBRANCH(CBRANCH), .JUMP(JUMP),
    .OP_A(OP_A), .OP_B(OP_B), .CMP1(CMP1), .CMP2(CMP2), .PC(PC), .PC_ID(PC_ID),
    .JUMP_BASE(JUMP_BASE), .JUMP_OFF(JUMP_OFF), .M_RESULT(M_RESULT), .M_READY(M_READY),
    .M_START(M_START), .OUT_VALID(OUT_VALID), .WB_DATA(WB_DATA), .DATA_ADDR(DATA_ADDR),
    .JUMP_FINAL(JUMP_FINAL), .JUMP_ADDR(JUMP_ADDR), .FLUSH(FLUSH), .STALL(STALL),
    .MISPREDICT_CNT(MISPREDICT_CNT)
  );

  exec_unit #(.CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .CACHE_READY(CACHE_READY), .IN_VALID(IN_VALID),
    .ALU_CNT(ALU_CNT), .FUN3(FUN3), .CBRANCH(CBRANCH), .JUMP(JUMP),
    .OP_A(OP_A), .OP_B(OP_B), .CMP1(CMP1), .CMP2(CMP2), .PC(PC), .PC_ID(PC_ID),
    .JUMP_BASE(JUMP_BASE), .JUMP_OFF(JUMP_OFF), .M_RESULT(M_RESULT), .M_READY(M_READY),
    .M_START(d2_m_start), .OUT_VALID(d2_out_valid), .WB_DATA(d2_wb), .DATA_ADDR(d2_addr),
    .JUMP_FINAL(d2_jump_final), .JUMP_ADDR(d2_jaddr), .FLUSH(d2_flush), .STALL(d2_stall),
    .MISPREDICT_CNT(d2_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] wb;
    logic [31:0] addr;
    int          due;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc_n = 0;

  always @(posedge CLK) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // Monitor: every OUT_VALID must match the oldest expected writeback and arrive on time.
  always @(negedge CLK) begin
    if (!RST && OUT_VALID === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 64'(OUT_VALID), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wb_data", 64'(WB_DATA), 64'(e.wb));
        chk("data_addr", 64'(DATA_ADDR), 64'(e.addr));
        chk("out_latency", 64'(cyc_n), 64'(e.due));
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    IN_VALID = 0; CBRANCH = 0; JUMP = 0; M_READY = 0; FUN3 = 0;
    ALU_CNT = ALU_IDLE; OP_A = 0; OP_B = 0; CMP1 = 0; CMP2 = 0;
    PC = 32'h40; PC_ID = 32'h44; JUMP_BASE = 0; JUMP_OFF = 0; M_RESULT = 0;
  endtask

  // Present a valid instruction and queue its writeback for the next cycle.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_wb);
    exp_t e;
    IN_VALID = 1; ALU_CNT = op; OP_A = a; OP_B = b;
    e.wb = exp_wb; e.addr = a + b; e.due = cyc_n + 1;
    q.push_back(e);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] c1;
    logic [31:0] c2;
    logic        taken;
  } br_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] wb;
  } alu_t;

  initial begin
    br_t  br_tab[9];
    alu_t alu_tab[9];
    int   nflush, nstall, nstart;

    br_tab[0] = '{3'd0, 32'd5, 32'd5, 1'b1};
    br_tab[1] = '{3'd1, 32'd5, 32'd5, 1'b0};
    br_tab[2] = '{3'd4, 32'd1, 32'hFFFF_FFFF, 1'b0};
    br_tab[3] = '{3'd5, 32'd1, 32'hFFFF_FFFF, 1'b1};
    br_tab[4] = '{3'd6, 32'd1, 32'hFFFF_FFFF, 1'b1};
    br_tab[5] = '{3'd7, 32'd1, 32'hFFFF_FFFF, 1'b0};
    br_tab[6] = '{3'd2, 32'd5, 32'd5, 1'b0};
    br_tab[7] = '{3'd3, 32'd5, 32'd6, 1'b0};
    br_tab[8] = '{3'd5, 32'd7, 32'd7, 1'b1};

    alu_tab[0] = '{ALU_ADD,   32'd5,         32'd7,         32'd12};
    alu_tab[1] = '{ALU_SUB,   32'd3,         32'd10,        32'd7};
    alu_tab[2] = '{ALU_SRA,   32'd4,         32'h8000_0000, 32'hF800_0000};
    alu_tab[3] = '{ALU_SLL,   32'd36,        32'd1,         32'h10};
    alu_tab[4] = '{ALU_SRL,   32'd4,         32'h8000_0000, 32'h0800_0000};
    alu_tab[5] = '{ALU_XOR,   32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F};
    alu_tab[6] = '{ALU_PASSA, 32'h1234,      32'd9,         32'h1234};
    alu_tab[7] = '{ALU_B4,    32'd0,         32'hFFFF_FFFC, 32'd0};
    alu_tab[8] = '{ALU_IDLE,  32'd1,         32'd2,         32'd0};

    clr();
    RST = 1; CACHE_READY = 1;
    cyc(); cyc();
    @(negedge CLK);
    chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_flush", 64'(FLUSH), 64'd0);
    chk("rst_cnt", 64'(MISPREDICT_CNT), 64'd0);
    chk("rst_stall", 64'(STALL), 64'd0);
    chk("rst_m_start", 64'(M_START), 64'd0);
    chk("rst_wb", 64'(WB_DATA), 64'd0);
    chk("rst_addr", 64'(DATA_ADDR), 64'd0);
    cyc();
    RST = 0;

    // Branch conditions observed while frozen, so nothing is accepted.
    CACHE_READY = 0;
    IN_VALID = 1; CBRANCH = 1; PC = 32'h80; PC_ID = 32'h84;
    foreach (br_tab[i]) begin
      FUN3 = br_tab[i].f3; CMP1 = br_tab[i].c1; CMP2 = br_tab[i].c2;
      @(negedge CLK);
      chk($sformatf("br_cond_f3_%0d_%0d", br_tab[i].f3, i), 64'(JUMP_FINAL), 64'(br_tab[i].taken));
      cyc();
    end
    CBRANCH = 0; JUMP = 1; JUMP_BASE = 32'hFFFF_FFF0; JUMP_OFF = 32'h20;
    @(negedge CLK);
    chk("jump_final_jal", 64'(JUMP_FINAL), 64'd1);
    chk("jump_addr_wrap", 64'(JUMP_ADDR), 64'h10);
    cyc();
    clr();
    CACHE_READY = 1;
    @(negedge CLK);
    chk("freeze_cnt", 64'(MISPREDICT_CNT), 64'd0);
    chk("freeze_out_valid", 64'(OUT_VALID), 64'd0);
    cyc();

    foreach (alu_tab[i]) begin
      drive(alu_tab[i].op, alu_tab[i].a, alu_tab[i].b, alu_tab[i].wb);
      cyc();
    end
    clr();
    cyc();
    @(negedge CLK);
    chk("alu_no_flush", 64'(FLUSH), 64'd0);
    chk("alu_no_redirect", 64'(MISPREDICT_CNT), 64'd0);
    cyc();

    // Taken LTU branch to 0x100 while decode holds PC+4.
    CBRANCH = 1; FUN3 = 3'd6; CMP1 = 32'd1; CMP2 = 32'hFFFF_FFFF;
    PC = 32'h200; PC_ID = 32'h204; JUMP_BASE = 32'h80; JUMP_OFF = 32'h80;
    drive(ALU_IDLE, 32'd0, 32'd0, 32'd0);
    @(negedge CLK);
    chk("br_jump_final", 64'(JUMP_FINAL), 64'd1);
    chk("br_jump_addr", 64'(JUMP_ADDR), 64'h100);
    cyc();
    clr();
    nflush = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (i == 0) chk("flush_starts", 64'(FLUSH), 64'd1);
      nflush += int'(FLUSH);
      cyc();
    end
    chk("flush_len", 64'(nflush), 64'd4);
    chk("cnt_after_br", 64'(MISPREDICT_CNT), 64'd1);

    // Correctly predicted jump: no redirect.
    JUMP = 1; JUMP_BASE = 32'h300; JUMP_OFF = 32'h10; PC = 32'h2F0; PC_ID = 32'h310;
    drive(ALU_B4, 32'd0, 32'h2F0, 32'h2F4);
    cyc();
    clr();
    @(negedge CLK);
    chk("pred_jump_no_flush", 64'(FLUSH), 64'd0);
    chk("pred_jump_cnt", 64'(MISPREDICT_CNT), 64'd1);
    cyc();

    // Redirect, then a second would-be redirect presented during the flush.
    JUMP = 1; JUMP_BASE = 32'h100; JUMP_OFF = 32'h0; PC = 32'h500; PC_ID = 32'h504;
    drive(ALU_IDLE, 32'd0, 32'd0, 32'd0);
    cyc();
    IN_VALID = 1; JUMP = 1; JUMP_BASE = 32'h900; PC = 32'h100; PC_ID = 32'h104;
    nflush = 0;
    @(negedge CLK);
    chk("masked_jump_final", 64'(JUMP_FINAL), 64'd0);
    chk("masked_stall", 64'(STALL), 64'd0);
    nflush += int'(FLUSH);
    cyc();
    clr();
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      nflush += int'(FLUSH);
      cyc();
    end
    chk("flush_len_double", 64'(nflush), 64'd4);
    chk("cnt_after_double", 64'(MISPREDICT_CNT), 64'd2);

    // M op answered after five wait cycles.
    nstall = 0; nstart = 0;
    IN_VALID = 1; ALU_CNT = ALU_MOP; OP_A = 32'd1; OP_B = 32'd2; PC = 32'h600; PC_ID = 32'h604;
    for (int i = 0; i <= 6; i++) begin
      if (i == 6) begin
        exp_t e;
        M_READY = 1; M_RESULT = 32'h1234;
        e.wb = 32'h1234; e.addr = 32'd3; e.due = cyc_n + 1;
        q.push_back(e);
      end
      @(negedge CLK);
      if (i == 0) chk("m_launch_stall", 64'(STALL), 64'd1);
      nstall += int'(STALL);
      nstart += int'(M_START);
      cyc();
    end
    clr();
    chk("m_stall_cycles", 64'(nstall), 64'd6);
    chk("m_start_pulses", 64'(nstart), 64'd1);
    cyc();

    // M result arriving while frozen is kept until the pipe advances.
    IN_VALID = 1; ALU_CNT = ALU_MOP; OP_A = 32'h10; OP_B = 32'h20; PC = 32'h700; PC_ID = 32'h704;
    cyc(); cyc(); cyc();
    CACHE_READY = 0; M_READY = 1; M_RESULT = 32'hBEEF;
    @(negedge CLK);
    chk("frz_ready_stall", 64'(STALL), 64'd0);
    chk("frz_m_start", 64'(M_START), 64'd0);
    cyc();
    M_READY = 0; M_RESULT = 32'h0;
    @(negedge CLK);
    chk("frz_held_stall", 64'(STALL), 64'd0);
    chk("frz_out_valid", 64'(OUT_VALID), 64'd0);
    cyc();
    begin
      exp_t e;
      e.wb = 32'hBEEF; e.addr = 32'h30; e.due = cyc_n + 1;
      q.push_back(e);
    end
    CACHE_READY = 1;
    cyc();
    clr();
    cyc();

    // Stray M_READY while idle.
    M_READY = 1; M_RESULT = 32'hDEAD;
    @(negedge CLK);
    chk("idle_mready_stall", 64'(STALL), 64'd0);
    cyc();
    M_READY = 0;
    @(negedge CLK);
    chk("idle_mready_no_out", 64'(OUT_VALID), 64'd0);
    cyc();

    // Reset in the middle of an M wait, then a late M_READY.
    IN_VALID = 1; ALU_CNT = ALU_MOP; OP_A = 32'd4; OP_B = 32'd4; PC = 32'h800; PC_ID = 32'h804;
    cyc(); cyc();
    clr();
    RST = 1;
    cyc();
    RST = 0; M_READY = 1; M_RESULT = 32'h5555;
    @(negedge CLK);
    chk("rst_mwait_stall", 64'(STALL), 64'd0);
    chk("rst_mwait_out", 64'(OUT_VALID), 64'd0);
    chk("rst_mwait_cnt", 64'(MISPREDICT_CNT), 64'd0);
    cyc();
    M_READY = 0;
    @(negedge CLK);
    chk("rst_stray_out", 64'(OUT_VALID), 64'd0);
    chk("rst_stray_stall", 64'(STALL), 64'd0);
    cyc();

    // Five redirects: the 2-bit counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) begin
        JUMP = 1; JUMP_BASE = 32'h700; JUMP_OFF = 32'(i * 4); PC = 32'h800; PC_ID = 32'h804;
      end else begin
        CBRANCH = 1; FUN3 = 3'd0; CMP1 = 32'd1; CMP2 = 32'd2; PC = 32'h900; PC_ID = 32'h1000;
      end
      drive(ALU_IDLE, 32'd0, 32'd0, 32'd0);
      cyc();
      clr();
      repeat (5) cyc();
      @(negedge CLK);
      chk($sformatf("sat_cnt16_%0d", i), 64'(MISPREDICT_CNT), 64'(i + 1));
      chk($sformatf("sat_cnt2_%0d", i), 64'(d2_cnt), 64'((i + 1 > 3) ? 3 : i + 1));
      cyc();
    end

    cyc(); cyc();
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (32 or 64).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 4, number of cycles FLUSH is held after a redirect (1..15).
REQ-003 SHALL have parameter CNT_W, default 16, width of the mispredict counter.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  synchronous active-high reset.
- CACHE_READY  in  1  global advance; low freezes all state.
- IN_VALID  in  1  EX instruction valid.
- ALU_CNT  in  4  ALU op code (package encoding).
- FUN3  in  3  branch condition or M-op select.
- CBRANCH  in  1  conditional branch.
- JUMP  in  1  unconditional jump (JAL/JALR).
- OP_A, OP_B  in  XLEN  ALU operands (OP_A = shift amount/rhs).
- CMP1, CMP2  in  XLEN  branch compare operands.
- PC  in  XLEN  PC of EX instruction.
- PC_ID  in  XLEN  PC currently in decode (predicted next).
- JUMP_BASE, JUMP_OFF  in  XLEN  target addends.
- M_RESULT  in  XLEN  multiply/divide result.
- M_READY  in  1  M result valid (one-cycle).
- M_START  out  1  one-cycle M-op launch pulse.
- OUT_VALID  out  1  registered result valid.
- WB_DATA  out  XLEN  registered writeback data.
- DATA_ADDR  out  XLEN  registered OP_A+OP_B (load/store address).
- JUMP_FINAL  out  1  combinational taken-redirect.
- JUMP_ADDR  out  XLEN  combinational JUMP_BASE+JUMP_OFF, modulo 2^XLEN.
- FLUSH  out  1  front-end flush.
- STALL  out  1  EX holding; upstream must freeze.
- MISPREDICT_CNT  out  CNT_W  redirect count.

Function
REQ-005 SHALL compute add, sub (B-A), sll, srl, sra, slt, sltu, xor, or, and, pass-A, pass-B, B+4, idle (0) per package codes; shift amount = OP_A[log2(XLEN)-1:0].
REQ-006 SHALL evaluate branch per FUN3: 0 eq, 1 ne, 4 lt, 5 ge, 6 ltu, 7 geu; FUN3 2/3 never taken.
REQ-007 SHALL drive JUMP_FINAL = IN_VALID & !flushing & (JUMP | (CBRANCH & cond)).
REQ-008 SHALL register WB_DATA, DATA_ADDR and OUT_VALID one cycle after acceptance (CACHE_READY & !STALL); latency 1 for non-M ops.
REQ-009 SHALL implement FSM M_IDLE/M_WAIT: valid M op in M_IDLE while not flushing -> M_START pulse, go M_WAIT; STALL=1 in M_WAIT until M_READY; on M_READY capture M_RESULT, OUT_VALID=1 next cycle, return M_IDLE.
REQ-010 SHALL, M op in M_IDLE, assert STALL combinationally in the launch cycle.
REQ-011 SHALL, at completion of a valid instruction, flag redirect if JUMP_FINAL ? PC_ID!=JUMP_ADDR : PC_ID!=PC+4.
REQ-012 SHALL, on redirect, assert FLUSH next cycle for exactly FLUSH_CYCLES advancing cycles via a down-counter; then deassert.
REQ-013 SHALL treat IN_VALID as 0 while FLUSH is high: OUT_VALID, JUMP_FINAL, M_START all 0; a redirect during flush is ignored (no restart).
REQ-014 SHALL increment MISPREDICT_CNT per redirect, saturating at all-ones.
REQ-015 SHALL freeze FSM, flush counter, output registers and MISPREDICT_CNT while CACHE_READY=0; M_READY in that cycle is still captured.
REQ-016 SHALL keep M_READY in M_IDLE without effect.

Reset
REQ-017 SHALL on RST: FSM=M_IDLE, FLUSH=0, flush counter=0, OUT_VALID=0, WB_DATA=0, DATA_ADDR=0, M_START=0, MISPREDICT_CNT=0; RST overrides CACHE_READY.
REQ-018 SHALL abandon an in-flight M op on RST mid-M_WAIT; a later M_READY is ignored.

Structure
REQ-019 SHALL take ALU op codes, branch FUN3 codes and FSM state encoding from shared package exec_pkg.
REQ-020 SHALL instantiate one sub-module branch_cmp (XLEN-parametrised comparator producing the condition bit).

Verification
REQ-021 XLEN=32, ALU_CNT=sra, OP_B=0x8000_0000, OP_A=4 -> next cycle WB_DATA=0xF800_0000, OUT_VALID=1.
REQ-022 CBRANCH, FUN3=6, CMP1=1, CMP2=0xFFFF_FFFF, PC_ID=PC+4, target 0x100 -> JUMP_FINAL=1, FLUSH high 4 cycles, MISPREDICT_CNT=1.
REQ-023 M op, M_READY after 5 cycles with 0x1234 -> single M_START pulse, STALL 6 cycles, WB_DATA=0x1234.
REQ-024 Second redirect during flush -> FLUSH still exactly 4 cycles total, counter +1 only.
REQ-025 RST mid-M_WAIT then stray M_READY -> STALL=0, OUT_VALID=0; CNT_W=2 after 5 redirects -> MISPREDICT_CNT=3.
